// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the ARM pipeline hazard unit.
//   fwd_sel_t  - E-stage ALU operand select (regfile / ResultW / ALUResultM)
//   stage_t    - E-stage shadow record {ra1, ra2, wa3, regwrite, memtoreg}
//   wb_stage_t - M/W-stage shadow record {wa3, regwrite}
// Address fields are REG_AW_MAX wide so one struct serves any REG_AW up to
// that width; narrower addresses are zero-extended on entry.
package hazard_pkg;

  localparam int REG_AW_DEF = 4;
  localparam int PC_REG_DEF = 15;
  localparam int CNT_W_DEF  = 16;
  localparam int REG_AW_MAX = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [REG_AW_MAX-1:0] ra1;
    logic [REG_AW_MAX-1:0] ra2;
    logic [REG_AW_MAX-1:0] wa3;
    logic                  regwrite;
    logic                  memtoreg;
  } stage_t;

  typedef struct packed {
    logic [REG_AW_MAX-1:0] wa3;
    logic                  regwrite;
  } wb_stage_t;

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// hazard_fwd_mux_sel: priority compare for one E-stage ALU operand.
//   ra_e         - source register of the operand in E
//   wa3_m, rw_m  - destination / write-enable of the instruction in M
//   wa3_w, rw_w  - destination / write-enable of the instruction in W
//   sel          - FWD_MEM if M matches, else FWD_WB if W matches, else FWD_RF
// The PC register is never forwarded: its E-stage value comes from the
// datapath's own PC+8 path, not from a writer further down the pipe.
module hazard_fwd_mux_sel
  import hazard_pkg::*;
#(
  parameter int PC_REG = PC_REG_DEF
) (
  input  logic [REG_AW_MAX-1:0] ra_e,
  input  logic [REG_AW_MAX-1:0] wa3_m,
  input  logic                  rw_m,
  input  logic [REG_AW_MAX-1:0] wa3_w,
  input  logic                  rw_w,
  output fwd_sel_t              sel
);

  localparam logic [REG_AW_MAX-1:0] PC_ADDR = REG_AW_MAX'(PC_REG);

  logic not_pc;

  always_comb begin
    not_pc = (ra_e != PC_ADDR);
    sel    = FWD_RF;
    // M is checked first: it holds the younger, and therefore newer, value.
    if (rw_m && (wa3_m == ra_e) && not_pc)      sel = FWD_MEM;
    else if (rw_w && (wa3_w == ra_e) && not_pc) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: hazard controller for the 5-stage ARM pipeline.
// Keeps its own shadow of E/M/W register usage and drives:
//   ForwardAE/ForwardBE - E operand selects (flop-derived, glitch-free)
//   StallF/StallD       - load-use stall of PC and IF/ID
//   FlushD/FlushE       - bubbles for taken branch / load-use
//   StallCount/FlushCount - saturating perf-debug event counters
// Inputs: D-stage RA1D/RA2D/WA3D/RegWriteD/MemtoRegD, E-stage BranchTakenE.
// clk rising edge; reset is synchronous active-low.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int PC_REG = PC_REG_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              BranchTakenE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam int NUM_OPS = 2;

  stage_t    e_q, e_d;
  wb_stage_t m_q, m_d, w_q, w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [REG_AW_MAX-1:0] ra1_d, ra2_d, wa3_d;
  logic ld_stall, flush_e;

  logic [NUM_OPS-1:0][REG_AW_MAX-1:0] ra_e;
  fwd_sel_t [NUM_OPS-1:0]             fwd_sel;

  assign ra1_d = REG_AW_MAX'(RA1D);
  assign ra2_d = REG_AW_MAX'(RA2D);
  assign wa3_d = REG_AW_MAX'(WA3D);

  // Branch-taken suppresses the stall: the dependent D instruction is
  // being flushed anyway, so holding it would only waste a cycle.
  always_comb begin
    ld_stall = e_q.memtoreg && e_q.regwrite &&
               ((e_q.wa3 == ra1_d) || (e_q.wa3 == ra2_d)) && !BranchTakenE;
    flush_e  = ld_stall || BranchTakenE;
  end

  assign StallF     = ld_stall;
  assign StallD     = ld_stall;
  assign FlushD     = BranchTakenE;
  assign FlushE     = flush_e;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

  // Shadow pipeline next state.
  always_comb begin
    e_d = '0;
    if (!flush_e) begin
      e_d.ra1      = ra1_d;
      e_d.ra2      = ra2_d;
      e_d.wa3      = wa3_d;
      e_d.regwrite = RegWriteD;
      e_d.memtoreg = MemtoRegD;
    end
    m_d.wa3      = e_q.wa3;
    m_d.regwrite = e_q.regwrite;
    w_d          = m_q;
  end

  // Saturating counters: hold at all-ones rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ld_stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (BranchTakenE && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // One priority compare per E operand (0 = A, 1 = B).
  assign ra_e[0] = e_q.ra1;
  assign ra_e[1] = e_q.ra2;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    hazard_fwd_mux_sel #(.PC_REG(PC_REG)) u_sel (
      .ra_e  (ra_e[g]),
      .wa3_m (m_q.wa3),
      .rw_m  (m_q.regwrite),
      .wa3_w (w_q.wa3),
      .rw_w  (w_q.regwrite),
      .sel   (fwd_sel[g])
    );
  end

  assign ForwardAE = fwd_sel[0];
  assign ForwardBE = fwd_sel[1];

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit. The stimulus process applies one
// vector per cycle and pushes its hand-computed expected outputs into a
// queue; a monitor on the falling edge pops and compares. A second instance
// with 2-bit counters exercises counter saturation in a short run.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] RA1D = '0, RA2D = '0, WA3D = '0;
  logic       RegWriteD = 1'b0, MemtoRegD = 1'b0, BranchTakenE = 1'b0;

  logic [1:0]  fa, fb, s_fa, s_fb;
  logic        stf, std, fld, fle, s_stf, s_std, s_fld, s_fle;
  logic [15:0] scnt, fcnt;
  logic [1:0]  s_scnt, s_fcnt;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchTakenE(BranchTakenE),
    .ForwardAE(fa), .ForwardBE(fb), .StallF(stf), .StallD(std),
    .FlushD(fld), .FlushE(fle), .StallCount(scnt), .FlushCount(fcnt)
  );

  hazard_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchTakenE(BranchTakenE),
    .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_stf), .StallD(s_std),
    .FlushD(s_fld), .FlushE(s_fle), .StallCount(s_scnt), .FlushCount(s_fcnt)
  );

  typedef struct {
    int          idx;
    logic        rst, chk;
    logic [3:0]  ra1, ra2, wa3;
    logic        rw, mr, bt;
    logic [1:0]  fa, fb;
    logic        st, fd, fe;
    logic [15:0] sc, fc;
    logic [1:0]  ssc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  logic chk_v = 1'b0;
  int   checks = 0, errors = 0;

  task automatic add(input logic rst, input logic chk,
                     input logic [3:0] ra1, input logic [3:0] ra2,
                     input logic [3:0] wa3, input logic rw, input logic mr,
                     input logic bt, input logic [1:0] efa, input logic [1:0] efb,
                     input logic est, input logic efd, input logic efe,
                     input logic [15:0] esc, input logic [15:0] efc,
                     input logic [1:0] essc);
    vec_t v;
    v.idx = vecs.size(); v.rst = rst; v.chk = chk;
    v.ra1 = ra1; v.ra2 = ra2; v.wa3 = wa3; v.rw = rw; v.mr = mr; v.bt = bt;
    v.fa = efa; v.fb = efb; v.st = est; v.fd = efd; v.fe = efe;
    v.sc = esc; v.fc = efc; v.ssc = essc;
    vecs.push_back(v);
  endtask

  task automatic cmp(input int idx, input string name,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  // Monitor: every checked cycle presents one expected record.
  always @(negedge clk) begin
    if (chk_v) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: got empty queue expected a record");
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        cmp(e.idx, "ForwardAE",  16'(fa),   16'(e.fa));
        cmp(e.idx, "ForwardBE",  16'(fb),   16'(e.fb));
        cmp(e.idx, "StallF",     16'(stf),  16'(e.st));
        cmp(e.idx, "StallD",     16'(std),  16'(e.st));
        cmp(e.idx, "FlushD",     16'(fld),  16'(e.fd));
        cmp(e.idx, "FlushE",     16'(fle),  16'(e.fe));
        cmp(e.idx, "StallCount", scnt,      e.sc);
        cmp(e.idx, "FlushCount", fcnt,      e.fc);
        cmp(e.idx, "sat_StallCount", 16'(s_scnt), 16'(e.ssc));
        cmp(e.idx, "sat_FlushCount", 16'(s_fcnt), (e.fc > 16'd3) ? 16'd3 : e.fc);
        cmp(e.idx, "sat_fwd",    16'({s_fa, s_fb}), 16'({e.fa, e.fb}));
        cmp(e.idx, "sat_ctl",    16'({s_stf, s_std, s_fld, s_fle}),
                                 16'({e.st, e.st, e.fd, e.fe}));
      end
    end
  end

  initial begin
    //   rst chk ra1 ra2 wa3 rw mr bt | fa fb st fd fe  sc fc ssc
    add(0, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0); // reset
    add(1, 1,  2,  3,  1, 1, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0); // ADD R1
    add(1, 1,  1,  3,  2, 1, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0); // SUB R2,R1,R3
    add(1, 1,  7,  1,  6, 1, 0, 0,   2, 0, 0, 0, 0,  0, 0, 0); // SUB in E: A<-M
    add(1, 1,  0,  0,  0, 0, 0, 0,   0, 1, 0, 0, 0,  0, 0, 0); // AND in E: B<-W
    add(1, 1,  0,  0,  4, 1, 1, 0,   0, 0, 0, 0, 0,  0, 0, 0); // LDR R4
    add(1, 1,  4,  4,  5, 1, 0, 0,   0, 0, 1, 0, 1,  0, 0, 0); // ADD R5,R4,R4 stall
    add(1, 1,  4,  4,  5, 1, 0, 0,   0, 0, 0, 0, 0,  1, 0, 1); // held, no stall
    add(1, 1,  0,  0,  0, 0, 0, 0,   1, 1, 0, 0, 0,  1, 0, 1); // ADD in E: both <-W
    add(1, 1,  0,  0,  4, 1, 1, 0,   0, 0, 0, 0, 0,  1, 0, 1); // LDR R4
    add(1, 1,  4,  4,  5, 1, 0, 1,   0, 0, 0, 1, 1,  1, 0, 1); // branch beats stall
    add(1, 1,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1); // FlushCount=1
    add(1, 1,  0,  0, 15, 1, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1); // writes R15
    add(1, 1, 15, 15,  3, 1, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1); // reads R15
    add(1, 1,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1); // R15 not forwarded
    add(1, 1,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1);
    add(1, 1,  0,  0,  3, 1, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1); // ADD R3 #1
    add(1, 1,  0,  0,  3, 1, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1); // ADD R3 #2
    add(1, 1,  3,  3,  8, 1, 0, 0,   0, 0, 0, 0, 0,  1, 1, 1); // SUB R8,R3,R3
    add(1, 1,  0,  0,  0, 0, 0, 0,   2, 2, 0, 0, 0,  1, 1, 1); // M beats W
    add(1, 1,  0,  0,  4, 1, 1, 0,   0, 0, 0, 0, 0,  1, 1, 1); // LDR
    add(1, 1,  4,  4,  5, 1, 0, 0,   0, 0, 1, 0, 1,  1, 1, 1); // stall
    add(1, 1,  4,  4,  5, 1, 0, 0,   0, 0, 0, 0, 0,  2, 1, 2);
    add(1, 1,  0,  0,  4, 1, 1, 0,   1, 1, 0, 0, 0,  2, 1, 2); // LDR
    add(1, 1,  4,  4,  5, 1, 0, 0,   0, 0, 1, 0, 1,  2, 1, 2); // stall
    add(1, 1,  4,  4,  5, 1, 0, 0,   0, 0, 0, 0, 0,  3, 1, 3); // small at max
    add(1, 1,  0,  0,  4, 1, 1, 0,   1, 1, 0, 0, 0,  3, 1, 3); // LDR
    add(1, 1,  4,  4,  5, 1, 0, 0,   0, 0, 1, 0, 1,  3, 1, 3); // stall
    add(1, 1,  4,  4,  5, 1, 0, 0,   0, 0, 0, 0, 0,  4, 1, 3); // small holds
    add(1, 1,  0,  0,  4, 1, 1, 0,   1, 1, 0, 0, 0,  4, 1, 3); // LDR
    add(0, 1,  4,  4,  5, 1, 0, 0,   0, 0, 1, 0, 1,  4, 1, 3); // reset mid-stall
    add(1, 1,  4,  4,  5, 1, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0); // all cleared
    add(1, 1,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0,  0, 0, 0); // no stale fwd

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      reset = vecs[i].rst;
      RA1D = vecs[i].ra1; RA2D = vecs[i].ra2; WA3D = vecs[i].wa3;
      RegWriteD = vecs[i].rw; MemtoRegD = vecs[i].mr; BranchTakenE = vecs[i].bt;
      chk_v = vecs[i].chk;
      if (vecs[i].chk) exp_q.push_back(vecs[i]);
    end
    @(posedge clk); #1;
    chk_v = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
